axa_issue_ctrl: RTL and testbench

// - Issue/interlock controller for the 4-stage pipelined AXA datapath (reg read, mem, ALU, reg write).
// - Decides each cycle whether the decoded instruction may enter register read, or stalls it.
// - Scoreboards pending register writes, serialises branch/jump resolution, drains the pipe on sys.
// - Sits between load/decode and register read; writeback and branch outcome come from the reg-write stage.
//

---
 rtl/axa_issue_ctrl_pkg.sv | 32 +++
 rtl/axa_scoreboard.sv | 82 ++++++++
 rtl/axa_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_axa_issue_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/axa_issue_ctrl_pkg.sv
// axa_issue_ctrl_pkg
//   Shared definitions for the AXA issue/interlock controller:
//   default sizing, register-id width, controller state encodings and
//   operand source types used by decode.
package axa_issue_ctrl_pkg;

  localparam int unsigned AXA_NREGS     = 16;
  localparam int unsigned AXA_DEPTH     = 4;
  localparam int unsigned AXA_FLUSH_CYC = 1;
  localparam int unsigned AXA_REG_W     = $clog2(AXA_NREGS);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_BJWAIT,
    ST_FLUSH,
    ST_DRAIN,
    ST_HALT
  } issue_state_e;

  typedef enum logic [1:0] {
    SRC_IMM,
    SRC_REG,
    SRC_ADDR,
    SRC_NONE
  } src_type_e;

  // Source types that read the register file during reg read
  function automatic logic src_is_reg(input src_type_e s);
    return (s == SRC_REG) || (s == SRC_ADDR);
  endfunction

endpackage

// File: rtl/axa_scoreboard.sv
// axa_scoreboard
//   Per-register pending-write counters (0..DEPTH) for the AXA issue
//   controller.
//   Ports:
//     clk, reset              clock, async active-low reset
//     inc_en/inc_id           a writer of inc_id was issued
//     dec_en/dec_id           a writer of dec_id retired
//     q0_id/q1_id             query ids (source, destination)
//     q0_busy/q1_busy         query register has an outstanding write
//     all_clear               no register has an outstanding write
//     inc_ovf/dec_unf         increment at DEPTH / decrement at 0 (saturated)
//   Config: AXA_ISSUE_BYPASS_EN waives busy for a register whose last
//   pending write retires this cycle (dec_en/dec_id double as bypass ids).
module axa_scoreboard
  import axa_issue_ctrl_pkg::*;
#(
  parameter  int unsigned NREGS = AXA_NREGS,
  parameter  int unsigned DEPTH = AXA_DEPTH,
  localparam int unsigned ID_W  = $clog2(NREGS),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_en,
  input  logic [ID_W-1:0] inc_id,
  input  logic            dec_en,
  input  logic [ID_W-1:0] dec_id,
  input  logic [ID_W-1:0] q0_id,
  input  logic [ID_W-1:0] q1_id,
  output logic            q0_busy,
  output logic            q1_busy,
  output logic            all_clear,
  output logic            inc_ovf,
  output logic            dec_unf
);

  logic [CNT_W-1:0] pend_q [NREGS];
  logic [CNT_W-1:0] pend_d [NREGS];
  logic [NREGS-1:0] inc_hit;
  logic [NREGS-1:0] dec_hit;

  always_comb begin
    inc_hit   = '0;
    dec_hit   = '0;
    inc_ovf   = 1'b0;
    dec_unf   = 1'b0;
    all_clear = 1'b1;
    for (int unsigned i = 0; i < NREGS; i++) begin
      inc_hit[i] = inc_en && (inc_id == ID_W'(i));
      dec_hit[i] = dec_en && (dec_id == ID_W'(i));
      pend_d[i]  = pend_q[i];
      // Simultaneous issue and retire on the same register cancel out
      if (inc_hit[i] && !dec_hit[i]) begin
        if (pend_q[i] == CNT_W'(DEPTH)) inc_ovf = 1'b1;
        else                            pend_d[i] = pend_q[i] + 1'b1;
      end else if (dec_hit[i] && !inc_hit[i]) begin
        if (pend_q[i] == '0) dec_unf = 1'b1;
        else                 pend_d[i] = pend_q[i] - 1'b1;
      end
      if (pend_q[i] != '0) all_clear = 1'b0;
    end
  end

  always_comb begin
    q0_busy = (pend_q[q0_id] != '0);
    q1_busy = (pend_q[q1_id] != '0);
`ifdef AXA_ISSUE_BYPASS_EN
    // Last outstanding write retiring now: reg-write forwards the result
    if (dec_en && (dec_id == q0_id) && (pend_q[q0_id] == CNT_W'(1))) q0_busy = 1'b0;
    if (dec_en && (dec_id == q1_id) && (pend_q[q1_id] == CNT_W'(1))) q1_busy = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) pend_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) pend_q[i] <= pend_d[i];
    end
  end

endmodule

// File: rtl/axa_issue_ctrl.sv
// axa_issue_ctrl
//   Issue/interlock controller for the 4-stage AXA pipeline. Decides each
//   cycle whether the decoded instruction enters register read, tracks
//   pending register writes, serialises branch resolution and drains the
//   pipe on sys.
//   Ports:
//     clk, reset                     clock, async active-low reset
//     issue_valid/dst/src/src_rd/wr/bj/sys   decoded instruction
//     retire_valid/wr/dst            instruction leaving reg-write
//     bj_resolve/bj_taken            branch outcome pulse
//     issue_ok                       instruction accepted (combinational)
//     stall                          decode must hold pc/ir
//     flush                          squash fetch/decode contents
//     halt                           sticky, sys has drained
//     inflight                       issued but unretired count
//   Config: define AXA_ISSUE_BYPASS_EN to let a dependent instruction issue
//   in its producer's retire cycle (reg-write must forward).
module axa_issue_ctrl
  import axa_issue_ctrl_pkg::*;
#(
  parameter  int unsigned NREGS     = AXA_NREGS,
  parameter  int unsigned DEPTH     = AXA_DEPTH,
  parameter  int unsigned FLUSH_CYC = AXA_FLUSH_CYC,
  localparam int unsigned ID_W      = $clog2(NREGS),
  localparam int unsigned INF_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [ID_W-1:0]  issue_dst,
  input  logic [ID_W-1:0]  issue_src,
  input  logic             issue_src_rd,
  input  logic             issue_wr,
  input  logic             issue_bj,
  input  logic             issue_sys,
  input  logic             retire_valid,
  input  logic             retire_wr,
  input  logic [ID_W-1:0]  retire_dst,
  input  logic             bj_resolve,
  input  logic             bj_taken,
  output logic             issue_ok,
  output logic             stall,
  output logic             flush,
  output logic             halt,
  output logic [INF_W-1:0] inflight
);

  localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  issue_state_e     state_q, state_d;
  logic [INF_W-1:0] inflight_q, inflight_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic src_busy, dst_busy, all_clear;
  logic sb_inc_ovf, sb_dec_unf;
  logic hazard;
  logic inf_ovf, inf_unf;
  logic bj_stray;

  axa_scoreboard #(
    .NREGS (NREGS),
    .DEPTH (DEPTH)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .inc_en    (issue_ok & issue_wr),
    .inc_id    (issue_dst),
    .dec_en    (retire_valid & retire_wr),
    .dec_id    (retire_dst),
    .q0_id     (issue_src),
    .q1_id     (issue_dst),
    .q0_busy   (src_busy),
    .q1_busy   (dst_busy),
    .all_clear (all_clear),
    .inc_ovf   (sb_inc_ovf),
    .dec_unf   (sb_dec_unf)
  );

  // Destination is always checked: the ALU reads it as an operand
  always_comb begin
    hazard   = (issue_src_rd & src_busy) | dst_busy;
    issue_ok = issue_valid & (state_q == ST_RUN) & ~hazard &
               (inflight_q < INF_W'(DEPTH));
    stall    = (issue_valid & ~issue_ok) | (state_q != ST_RUN);
    flush    = (state_q == ST_FLUSH);
    halt     = (state_q == ST_HALT);
    inflight = inflight_q;
  end

  always_comb begin
    inflight_d = inflight_q;
    inf_ovf    = 1'b0;
    inf_unf    = 1'b0;
    if (issue_ok && !retire_valid) begin
      if (inflight_q == INF_W'(DEPTH)) inf_ovf = 1'b1;
      else                             inflight_d = inflight_q + 1'b1;
    end else if (retire_valid && !issue_ok) begin
      if (inflight_q == '0) inf_unf = 1'b1;
      else                  inflight_d = inflight_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    bj_stray    = bj_resolve && (state_q != ST_BJWAIT);
    case (state_q)
      ST_RUN: begin
        if (issue_ok && issue_bj)       state_d = ST_BJWAIT;
        else if (issue_ok && issue_sys) state_d = ST_DRAIN;
      end
      ST_BJWAIT: begin
        if (bj_resolve) begin
          if (bj_taken) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYC - 1);
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == '0) state_d = ST_RUN;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) && all_clear) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      inflight_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      if (bj_stray)
        $warning("axa_issue_ctrl: bj_resolve outside BJWAIT ignored");
      if (sb_inc_ovf || sb_dec_unf)
        $warning("axa_issue_ctrl: scoreboard counter saturated");
      if (inf_ovf || inf_unf)
        $warning("axa_issue_ctrl: inflight counter saturated");
    end
  end
`endif

endmodule

// File: tb/tb_axa_issue_ctrl.sv
module tb_axa_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       issue_valid = 1'b0;
  logic [3:0] issue_dst = '0;
  logic [3:0] issue_src = '0;
  logic       issue_src_rd = 1'b0;
  logic       issue_wr = 1'b0;
  logic       issue_bj = 1'b0;
  logic       issue_sys = 1'b0;
  logic       retire_valid = 1'b0;
  logic       retire_wr = 1'b0;
  logic [3:0] retire_dst = '0;
  logic       bj_resolve = 1'b0;
  logic       bj_taken = 1'b0;
  logic       issue_ok, stall, flush, halt;
  logic [2:0] inflight;

  axa_issue_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_dst    (issue_dst),
    .issue_src    (issue_src),
    .issue_src_rd (issue_src_rd),
    .issue_wr     (issue_wr),
    .issue_bj     (issue_bj),
    .issue_sys    (issue_sys),
    .retire_valid (retire_valid),
    .retire_wr    (retire_wr),
    .retire_dst   (retire_dst),
    .bj_resolve   (bj_resolve),
    .bj_taken     (bj_taken),
    .issue_ok     (issue_ok),
    .stall        (stall),
    .flush        (flush),
    .halt         (halt),
    .inflight     (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] exp;   // {issue_ok, stall, flush, halt, inflight[2:0]}
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [6:0] E(input logic ok, input logic st, input logic fl,
                                   input logic ha, input logic [2:0] inf);
    return {ok, st, fl, ha, inf};
  endfunction

  // Monitor: the DUT presents its outputs every cycle; compare on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = exp_q.pop_front();
      act = {issue_ok, stall, flush, halt, inflight};
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got ok/stall/flush/halt/inflight=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                 e.name, act[6], act[5], act[4], act[3], act[2:0],
                 e.exp[6], e.exp[5], e.exp[4], e.exp[3], e.exp[2:0]);
      end
    end
  end

  // One cycle of stimulus. rst_lo holds reset low from now until just after
  // the check, with no rising edge in between.
  task automatic vec(input string nm, input logic rst_lo,
                     input logic v, input logic [3:0] dst, input logic [3:0] src,
                     input logic rd, input logic wr, input logic bj, input logic sys,
                     input logic rv, input logic rwr, input logic [3:0] rdst,
                     input logic bjr, input logic bjt, input logic [6:0] exp);
    exp_t e;
    issue_valid = v;   issue_dst = dst; issue_src = src; issue_src_rd = rd;
    issue_wr = wr;     issue_bj = bj;   issue_sys = sys;
    retire_valid = rv; retire_wr = rwr; retire_dst = rdst;
    bj_resolve = bjr;  bj_taken = bjt;
    if (rst_lo) reset = 1'b0;
    e.name = nm;
    e.exp  = exp;
    exp_q.push_back(e);
    if (rst_lo) begin
      @(negedge clk);
      #2 reset = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    //  name            rst v  dst    src    rd wr bj sy rv rw rdst  br bt  expected
    vec("reset_state",   1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,0,0,0,0));
    vec("indep_r1",      0, 1, 4'd1,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("indep_r2",      0, 1, 4'd2,  4'd5,  1, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,1));
    vec("indep_r3",      0, 1, 4'd3,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,2));
    vec("raw_stall_a",   0, 1, 4'd4,  4'd3,  1, 1, 0, 0, 1, 1, 4'd1, 0, 0, E(0,1,0,0,3));
    vec("raw_stall_b",   0, 1, 4'd4,  4'd3,  1, 1, 0, 0, 1, 1, 4'd2, 0, 0, E(0,1,0,0,2));
`ifdef AXA_ISSUE_BYPASS_EN
    vec("raw_retire",    0, 1, 4'd4,  4'd3,  1, 1, 0, 0, 1, 1, 4'd3, 0, 0, E(1,0,0,0,1));
    vec("raw_after",     0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,0,0,0,1));
`else
    vec("raw_retire",    0, 1, 4'd4,  4'd3,  1, 1, 0, 0, 1, 1, 4'd3, 0, 0, E(0,1,0,0,1));
    vec("raw_after",     0, 1, 4'd4,  4'd3,  1, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
`endif
    vec("waw_dst_haz",   0, 1, 4'd4,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,1));
    vec("src_not_read",  0, 1, 4'd6,  4'd4,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,1));
    vec("ret_r4",        0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd4, 0, 0, E(0,0,0,0,2));
    vec("ret_r6",        0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd6, 0, 0, E(0,0,0,0,1));
    // branch taken
    vec("bj_issue",      0, 1, 4'd0,  4'd0,  0, 0, 1, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("bjwait_stall",  0, 1, 4'd7,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,1));
    vec("bj_res_taken",  0, 1, 4'd7,  4'd0,  0, 1, 0, 0, 1, 0, 4'd0, 1, 1, E(0,1,0,0,1));
    vec("flush_cycle",   0, 1, 4'd7,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,1,0,0));
    vec("post_flush",    0, 1, 4'd7,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("ret_r7",        0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd7, 0, 0, E(0,0,0,0,1));
    // branch not taken
    vec("bj2_issue",     0, 1, 4'd0,  4'd0,  0, 0, 1, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("bj2_not_taken", 0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 0, 4'd0, 1, 0, E(0,1,0,0,1));
    vec("nt_resume",     0, 1, 4'd8,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    // fill to DEPTH
    vec("fill_r9",       0, 1, 4'd9,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,1));
    vec("fill_r10",      0, 1, 4'd10, 4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,2));
    vec("fill_r11",      0, 1, 4'd11, 4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,3));
    vec("depth_full",    0, 1, 4'd12, 4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,4));
    vec("depth_ret",     0, 1, 4'd12, 4'd0,  0, 1, 0, 0, 1, 1, 4'd8, 0, 0, E(0,1,0,0,4));
    vec("depth_room",    0, 1, 4'd12, 4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,3));
    vec("ret_r9",        0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd9, 0, 0, E(0,0,0,0,4));
    vec("ret_r10",       0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd10,0, 0, E(0,0,0,0,3));
    // sys drain with two writers outstanding
    vec("sys_issue",     0, 1, 4'd0,  4'd0,  0, 0, 0, 1, 0, 0, 4'd0, 0, 0, E(1,0,0,0,2));
    vec("drain_r11",     0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd11,0, 0, E(0,1,0,0,3));
    vec("drain_r12",     0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 1, 4'd12,0, 0, E(0,1,0,0,2));
    vec("drain_sys",     0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 1, 0, 4'd0, 0, 0, E(0,1,0,0,1));
    vec("drain_empty",   0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,0));
    vec("halt_set",      0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,1,0));
    vec("halt_sticky",   0, 1, 4'd1,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,1,0));
    // reset out of halt, then reset asserted mid-branch with three in flight
    vec("reset_halt",    1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,0,0,0,0));
    vec("mr_r1",         0, 1, 4'd1,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("mr_r2",         0, 1, 4'd2,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,1));
    vec("mr_bj",         0, 1, 4'd0,  4'd0,  0, 0, 1, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,2));
    vec("mr_bjwait",     0, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,3));
    vec("mr_reset",      1, 0, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 4'd0, 0, 0, E(0,0,0,0,0));
    vec("mr_pend_clr",   0, 1, 4'd1,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(1,0,0,0,0));
    vec("mr_reissue",    0, 1, 4'd1,  4'd0,  0, 1, 0, 0, 0, 0, 4'd0, 0, 0, E(0,1,0,0,1));
    issue_valid = 1'b0;
    retire_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
